// File: rtl/conv2d_window_scanner_if.sv
// Beat bundle between the window scanner and the Conv2d MAC datapath.
// One beat = feature-map address, weight index and boundary flags.
interface conv2d_window_scanner_if #(
  parameter int ADDR_W = 10,
  parameter int WI_W   = 4
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [WI_W-1:0]   w_idx;
  logic              pad;
  logic              tap_last;
  logic              frame_last;

  modport master (
    output addr_valid, addr, w_idx,
    output pad, tap_last, frame_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, addr, w_idx,
    input  pad, tap_last, frame_last,
    output addr_ready
  );
endinterface

// File: rtl/conv2d_window_scanner.sv
// Stride-1 Conv2d window scanner: kx,ky,ox,oy nested loop address walk.
// Define CONV2D_SCAN_PAD_EN for "same" zero padding (K must be odd).
module conv2d_window_scanner #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  conv2d_window_scanner_if.master m
);

  localparam int WW = (K * K > 1) ? $clog2(K * K) : 1;
`ifdef CONV2D_SCAN_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
`endif
  localparam int MX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] K_M1  = CW'(K - 1);
  localparam logic [CW-1:0] OW_M1 = CW'(OW - 1);
  localparam logic [CW-1:0] OH_M1 = CW'(OH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] kx, ky, ox, oy;
  logic [CW-1:0] kx_n, ky_n, ox_n, oy_n;
  logic          load, adv, acc;
  logic          valid_n, busy_n, done_n;

  logic [ADDR_W-1:0] addr_n;
  logic [WW-1:0]     widx_n;
  logic              tl_n, fl_n;
  int                tx, ty, a;
`ifdef CONV2D_SCAN_PAD_EN
  logic              pad_n;
`endif

  assign acc = m.addr_valid & m.addr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          load    = 1'b1;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        busy_n  = 1'b1;
        valid_n = 1'b1;
        if (acc) begin
          adv = 1'b1;
          if (m.frame_last) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Odometer: each index wraps and carries into the next outer loop.
  always_comb begin
    kx_n = kx;
    ky_n = ky;
    ox_n = ox;
    oy_n = oy;
    if (load) begin
      kx_n = '0;
      ky_n = '0;
      ox_n = '0;
      oy_n = '0;
    end else if (adv) begin
      kx_n = (kx == K_M1) ? '0 : kx + 1'b1;
      if (kx == K_M1) begin
        ky_n = (ky == K_M1) ? '0 : ky + 1'b1;
        if (ky == K_M1) begin
          ox_n = (ox == OW_M1) ? '0 : ox + 1'b1;
          if (ox == OW_M1)
            oy_n = (oy == OH_M1) ? '0 : oy + 1'b1;
        end
      end
    end
  end

  // Beat fields are derived from the next indices so they register
  // together with the indices they describe.
  always_comb begin
    tx = int'(ox_n) + int'(kx_n);
    ty = int'(oy_n) + int'(ky_n);
`ifdef CONV2D_SCAN_PAD_EN
    tx    = tx - P;
    ty    = ty - P;
    pad_n = (tx < 0) || (tx >= IMG_W) ||
            (ty < 0) || (ty >= IMG_H);
    a     = pad_n ? 0 : ty * IMG_W + tx;
`else
    a     = ty * IMG_W + tx;
`endif
    addr_n = ADDR_W'(a);
    widx_n = WW'(int'(ky_n) * K + int'(kx_n));
    tl_n   = (kx_n == K_M1) && (ky_n == K_M1);
    fl_n   = tl_n && (ox_n == OW_M1) &&
             (oy_n == OH_M1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kx           <= '0;
      ky           <= '0;
      ox           <= '0;
      oy           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m.addr_valid <= 1'b0;
      m.addr       <= '0;
      m.w_idx      <= '0;
      m.tap_last   <= 1'b0;
      m.frame_last <= 1'b0;
`ifdef CONV2D_SCAN_PAD_EN
      m.pad        <= 1'b0;
`endif
    end else begin
      kx           <= kx_n;
      ky           <= ky_n;
      ox           <= ox_n;
      oy           <= oy_n;
      busy         <= busy_n;
      done         <= done_n;
      m.addr_valid <= valid_n;
      if (load || adv) begin
        m.addr       <= addr_n;
        m.w_idx      <= widx_n;
        m.tap_last   <= tl_n;
        m.frame_last <= fl_n;
`ifdef CONV2D_SCAN_PAD_EN
        m.pad        <= pad_n;
`endif
      end
    end
  end

`ifndef CONV2D_SCAN_PAD_EN
  assign m.pad = 1'b0;
`endif

endmodule

// File: tb/tb_conv2d_window_scanner.sv
// Self-checking bench for conv2d_window_scanner: reference beat list
// from nested loops, constant vector table, backpressure and resets.
module tb_conv2d_window_scanner;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int K      = 3;
  localparam int ADDR_W = 10;
  localparam int WW = (K * K > 1) ? $clog2(K * K) : 1;
`ifdef CONV2D_SCAN_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
`endif
  localparam int N = OW * OH * K * K;

  typedef struct {
    int beat;
    int addr;
    int w;
    bit pad;
    bit tl;
    bit fl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;

  logic [63:0] expq[$];
  logic [63:0] got[$];
  vec_t        tbl[$];

  conv2d_window_scanner_if #(
    .ADDR_W(ADDR_W),
    .WI_W  (WW)
  ) bus ();

  conv2d_window_scanner #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .busy (busy),
    .done (done),
    .m    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(bit p, bit tl,
                                     bit fl, int w, int a);
    return {29'b0, p, tl, fl, 16'(w), 16'(a)};
  endfunction

  function automatic logic [63:0] cur();
    return pk(bus.pad, bus.tap_last, bus.frame_last,
              int'(bus.w_idx), int'(bus.addr));
  endfunction

  function automatic vec_t mkv(int b, int a, int w,
                               bit p, bit tl, bit fl);
    vec_t v;
    v.beat = b;
    v.addr = a;
    v.w    = w;
    v.pad  = p;
    v.tl   = tl;
    v.fl   = fl;
    return v;
  endfunction

  task automatic build_model();
    int tx, ty, a;
    bit p, tl, fl;
    expq.delete();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            tx = ox + kx;
            ty = oy + ky;
            p  = 1'b0;
`ifdef CONV2D_SCAN_PAD_EN
            tx = tx - P;
            ty = ty - P;
            p  = (tx < 0) || (tx >= IMG_W) ||
                 (ty < 0) || (ty >= IMG_H);
`endif
            a  = p ? 0 : ty * IMG_W + tx;
            tl = (kx == K - 1) && (ky == K - 1);
            fl = tl && (ox == OW - 1) && (oy == OH - 1);
            expq.push_back(pk(p, tl, fl, ky * K + kx, a));
          end
  endtask

  task automatic run_frame(int pct, bit spam);
    int idx, cyc;
    bit r, stall;
    logic [63:0] snap;
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_valid", 64'(bus.addr_valid), 64'd1);
    chk("first_busy", 64'(busy), 64'd1);
    idx   = 0;
    cyc   = 0;
    stall = 1'b0;
    snap  = '0;
    while (idx < N && cyc < 4000) begin
      if (stall) chk("stall_hold", cur(), snap);
      chk("scan_valid", 64'(bus.addr_valid), 64'd1);
      chk("scan_busy", 64'(busy), 64'd1);
      chk("scan_done", 64'(done), 64'd0);
      r = ($urandom_range(99) < pct);
      bus.addr_ready = r;
      if (spam) start = 1'($urandom_range(1));
      if (r) begin
        chk("beat", cur(), expq[idx]);
        got.push_back(cur());
        idx++;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        snap  = cur();
      end
      step();
      cyc++;
    end
    chk("beat_count", 64'(idx), 64'(N));
    if (pct >= 100) chk("no_bubbles", 64'(cyc), 64'(N));
    bus.addr_ready = 1'b0;
    start = spam;
    chk("done_valid", 64'(bus.addr_valid), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    step();
    start = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_valid", 64'(bus.addr_valid), 64'd0);
  endtask

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    bus.addr_ready = 1'b0;
    build_model();
`ifdef CONV2D_SCAN_PAD_EN
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 1, 0, 0));
    tbl.push_back(mkv(2, 0, 2, 1, 0, 0));
    tbl.push_back(mkv(3, 0, 3, 1, 0, 0));
    tbl.push_back(mkv(4, 0, 4, 0, 0, 0));
    tbl.push_back(mkv(5, 1, 5, 0, 0, 0));
    tbl.push_back(mkv(6, 0, 6, 1, 0, 0));
    tbl.push_back(mkv(7, 5, 7, 0, 0, 0));
    tbl.push_back(mkv(8, 6, 8, 0, 1, 0));
    tbl.push_back(mkv(224, 0, 8, 1, 1, 1));
`else
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0));
    tbl.push_back(mkv(2, 2, 2, 0, 0, 0));
    tbl.push_back(mkv(3, 5, 3, 0, 0, 0));
    tbl.push_back(mkv(4, 6, 4, 0, 0, 0));
    tbl.push_back(mkv(5, 7, 5, 0, 0, 0));
    tbl.push_back(mkv(6, 10, 6, 0, 0, 0));
    tbl.push_back(mkv(7, 11, 7, 0, 0, 0));
    tbl.push_back(mkv(8, 12, 8, 0, 1, 0));
    tbl.push_back(mkv(9, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(27, 5, 0, 0, 0, 0));
    tbl.push_back(mkv(80, 24, 8, 0, 1, 1));
`endif

    for (int i = 0; i < 4; i++) begin
      start = i[0];
      step();
      chk("rst_fields", cur(), 64'd0);
      chk("rst_ctl", 64'({busy, done, bus.addr_valid}),
          64'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    step();

    run_frame(100, 1'b0);
    for (int i = 0; i < tbl.size(); i++)
      chk($sformatf("tbl_beat%0d", tbl[i].beat),
          (tbl[i].beat < got.size()) ?
            got[tbl[i].beat] : '1,
          pk(tbl[i].pad, tbl[i].tl, tbl[i].fl,
             tbl[i].w, tbl[i].addr));
    step();

    run_frame(50, 1'b0);
    step();

    run_frame(100, 1'b1);
    run_frame(100, 1'b0);
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    bus.addr_ready = 1'b1;
    repeat (40) step();
    chk("mid_beat40", cur(), expq[40]);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.addr_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    bus.addr_ready = 1'b0;
    step();
    step();
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_idle", 64'(bus.addr_valid), 64'd0);
    reset = 1'b1;
    step();
    run_frame(70, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
